// File: rtl/ir_queue_if.sv
// ir_queue_if: control/status bundle between the sequencer and the instruction register/prefetch queue.
// Ports: load/next/flush/enl/enh from the sequencer; value/valid/count/full/empty back from the queue.
// The shared data bus is not carried here; it stays a plain inout on the block.
interface ir_queue_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             load;
   logic             next;
   logic             flush;
   logic             enl;
   logic             enh;
   logic [WIDTH-1:0] value;
   logic             valid;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   // Sequencer side
   modport master (
      output load, next, flush, enl, enh,
      input  value, valid, count, full, empty
   );

   // Queue side
   modport slave (
      input  load, next, flush, enl, enh,
      output value, valid, count, full, empty
   );
endinterface

// File: rtl/ir_queue.sv
// ir_queue: instruction register fed by a DEPTH-entry prefetch FIFO, with immediate drive-back onto the bus.
// Latency: 1 edge load->value when bypassing an empty queue, else 1 edge to enqueue + one next per word ahead.
// Backpressure: none; a push into a full queue is dropped unless a pop happens on the same edge.
// Ports: clk, reset (sync, active-high), bus (inout tristate data bus), ifc (ir_queue_if.slave).
module ir_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int IMMW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire  [WIDTH-1:0] bus,
   ir_queue_if.slave        ifc
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;

   logic             mem_we;
   logic [PW-1:0]    mem_waddr;
   logic             pushen;
   logic             q_full;
   logic             q_empty;
   logic             drv_en;
   logic [WIDTH-1:0] drv_dat;

   // A load while we drive the bus would capture our own immediate, so it is suppressed.
   assign pushen  = ifc.load & ~ifc.enl & ~ifc.enh;
   assign q_full  = (count_q == CW'(DEPTH));
   assign q_empty = (count_q == '0);

   always_comb begin
      value_d   = value_q;
      valid_d   = valid_q;
      count_d   = count_q;
      head_d    = head_q;
      tail_d    = tail_q;
      mem_we    = 1'b0;
      mem_waddr = tail_q;

      if (ifc.flush) begin
         // Restart both pointers at 0; an accompanying push lands in slot 0.
         head_d    = '0;
         mem_waddr = '0;
         if (pushen) begin
            mem_we  = 1'b1;
            tail_d  = PW'(1);
            count_d = CW'(1);
         end else begin
            tail_d  = '0;
            count_d = '0;
         end
      end else if (ifc.next && !q_empty) begin
         value_d = mem_q[head_q];
         valid_d = 1'b1;
         head_d  = head_q + PW'(1);
         if (pushen) begin
            // When full, tail == head: the slot being read this edge is rewritten, which is safe.
            mem_we = 1'b1;
            tail_d = tail_q + PW'(1);
         end else begin
            count_d = count_q - CW'(1);
         end
      end else if (ifc.next && pushen) begin
         // Empty queue: the bus word goes straight to the instruction register.
         value_d = bus;
         valid_d = 1'b1;
      end else if (ifc.next) begin
         valid_d = 1'b0;
      end else if (pushen && !q_full) begin
         mem_we  = 1'b1;
         tail_d  = tail_q + PW'(1);
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         value_q <= value_d;
         valid_q <= valid_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Queue storage has no reset; contents are only read behind a nonzero count.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         mem_q[mem_waddr] <= bus;
      end
   end

   // Immediate drive-back: enh wins and fills the upper bits with ones. Not gated by reset.
   always_comb begin
      drv_en  = ifc.enl | ifc.enh;
      drv_dat = {{(WIDTH-IMMW){ifc.enh}}, value_q[IMMW-1:0]};
   end

   assign bus = drv_en ? drv_dat : {WIDTH{1'bz}};

   assign ifc.value = value_q;
   assign ifc.valid = valid_q;
   assign ifc.count = count_q;
   assign ifc.full  = q_full;
   assign ifc.empty = q_empty;
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: self-checking bench for ir_queue using a queue model and a scoreboard of expected values.
module tb_ir_queue;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int IMMW  = 8;

   logic             clk;
   logic             reset;
   wire  [WIDTH-1:0] bus;
   logic [WIDTH-1:0] tb_bus;
   logic             tb_bus_en;

   ir_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

   ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMMW(IMMW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .ifc   (ifc)
   );

   assign bus = tb_bus_en ? tb_bus : {WIDTH{1'bz}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] m_value;
   bit               m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge with the given controls; updates the model, then checks all registered outputs.
   task automatic step(input bit rst, input bit ld, input bit nx, input bit fl,
                       input bit el, input bit eh, input logic [WIDTH-1:0] d);
      bit pe;
      logic [WIDTH-1:0] v;
      pe        = ld & ~el & ~eh;
      reset     = rst;
      ifc.load  = ld;
      ifc.next  = nx;
      ifc.flush = fl;
      ifc.enl   = el;
      ifc.enh   = eh;
      tb_bus    = d;
      tb_bus_en = pe;

      if (rst) begin
         m_q.delete();
         m_value = '0;
         m_valid = 1'b0;
      end else if (fl) begin
         m_q.delete();
         if (pe) m_q.push_back(d);
      end else if (nx && m_q.size() > 0) begin
         v = m_q.pop_front();
         if (pe) m_q.push_back(d);
         m_value = v;
         m_valid = 1'b1;
         sb_q.push_back(v);
      end else if (nx && pe) begin
         m_value = d;
         m_valid = 1'b1;
         sb_q.push_back(d);
      end else if (nx) begin
         m_valid = 1'b0;
      end else if (pe && m_q.size() < DEPTH) begin
         m_q.push_back(d);
      end

      @(posedge clk);
      #1;
      reset     = 1'b0;
      ifc.load  = 1'b0;
      ifc.next  = 1'b0;
      ifc.flush = 1'b0;
      ifc.enl   = 1'b0;
      ifc.enh   = 1'b0;
      tb_bus_en = 1'b0;

      if (sb_q.size() > 0) begin
         v = sb_q.pop_front();
         check("value_pop", 32'(ifc.value), 32'(v));
      end else begin
         check("value_hold", 32'(ifc.value), 32'(m_value));
      end
      check("valid", 32'(ifc.valid), 32'(m_valid));
      check("count", 32'(ifc.count), 32'(m_q.size()));
      check("full",  32'(ifc.full),  32'(m_q.size() == DEPTH));
      check("empty", 32'(ifc.empty), 32'(m_q.size() == 0));
   endtask

   // Combinational bus drive check; the bench drives a marker when the DUT should release the bus.
   task automatic bus_chk(input string tag, input bit el, input bit eh, input logic [WIDTH-1:0] exp);
      ifc.enl   = el;
      ifc.enh   = eh;
      tb_bus    = 16'h1234;
      tb_bus_en = ~el & ~eh;
      #1;
      check(tag, 32'(bus), 32'(exp));
      ifc.enl   = 1'b0;
      ifc.enh   = 1'b0;
      tb_bus_en = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      ifc.load  = 1'b0;
      ifc.next  = 1'b0;
      ifc.flush = 1'b0;
      ifc.enl   = 1'b0;
      ifc.enh   = 1'b0;
      tb_bus    = '0;
      tb_bus_en = 1'b0;
      m_value   = '0;
      m_valid   = 1'b0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 16'd0);
      step(1, 0, 0, 0, 0, 0, 16'd0);

      // Bypass into an empty queue, then immediate drive-back
      step(0, 1, 1, 0, 0, 0, 16'd40400);
      bus_chk("bus_enl",  1, 0, 16'd208);
      bus_chk("bus_enh",  0, 1, 16'd65488);
      bus_chk("bus_both", 1, 1, 16'd65488);
      bus_chk("bus_hiz",  0, 0, 16'h1234);

      // Fill, overflow drop, drain, underflow
      for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, 0, 16'(i));
      for (int i = 0; i < 5; i++)  step(0, 0, 1, 0, 0, 0, 16'd0);

      // Push+pop while full exercises pointer wrap
      for (int i = 10; i <= 13; i++) step(0, 1, 0, 0, 0, 0, 16'(i));
      step(0, 1, 1, 0, 0, 0, 16'd14);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 16'd0);

      // Flush with simultaneous load and next
      step(0, 1, 0, 0, 0, 0, 16'd20);
      step(0, 1, 0, 0, 0, 0, 16'd21);
      step(0, 1, 1, 1, 0, 0, 16'd99);
      step(0, 0, 1, 0, 0, 0, 16'd0);

      // Load suppressed while driving the bus, then accepted
      step(0, 1, 0, 0, 1, 0, 16'd65535);
      step(0, 1, 0, 0, 0, 1, 16'd65535);
      step(0, 1, 0, 0, 0, 0, 16'd7);

      // Reset mid-fill overrides load and next
      step(0, 1, 0, 0, 0, 0, 16'd8);
      step(0, 1, 0, 0, 0, 0, 16'd9);
      step(1, 1, 1, 0, 0, 0, 16'd55);

      // Mixed random traffic
      for (int i = 0; i < 200; i++) begin
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0), 0, 0, 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
